// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg -- shared definitions for the data-memory bus controller.
//   FSM state encoding, the all-ones error read value and the default
//   no-ack abort limit.
package mem_bus_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Wide enough for any DATA_W up to 64; users take the low DATA_W bits.
    localparam logic [63:0] MEM_BUS_ERR_DATA = '1;

    localparam int MEM_BUS_TIMEOUT_DEF = 15;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if -- req/ack memory-side bus of the data-memory controller.
//   master : controller side (drives mem_addr/mem_wdata/mem_req/mem_we,
//            receives mem_ack/mem_rdata)
//   slave  : memory side
interface mem_bus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_req;
    logic              mem_we;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_req, mem_we,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_req, mem_we,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_bus_wbuf.sv
// mem_bus_wbuf -- one-entry posted-write buffer.
//   clk, rst            : clock, async active-high reset
//   load                : capture load_addr/load_data, set valid
//   clr                 : drop the entry (drain finished); load wins over clr
//   valid, addr, data   : buffered store
module mem_bus_wbuf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            data  <= load_data;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl -- data-memory bus controller between the CPU data port and a
// variable-latency req/ack memory.
//   clk, rst   : clock, async active-high reset
//   cpu_*      : core data port (addr, wdata, read, wrt in; rdata, stall out)
//   mem        : memory bus (mem_bus_ctrl_if.master)
//   bus_err    : sticky no-ack abort flag
// Optional: define MEM_BUS_WRITE_BUF_EN to compile in a one-entry posted-write
// buffer so stores complete without stalling the core.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = MEM_BUS_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_wrt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              bus_err,
    mem_bus_ctrl_if.master    mem
);
    // Abort fires at the edge ending the TIMEOUT-th unacked WAIT cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [7:0]        tmo_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              req_q;
    logic              we_q;
    logic              req;
    logic              tmo_hit;

    assign req     = cpu_read | cpu_wrt;
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;

`ifdef MEM_BUS_WRITE_BUF_EN
    logic              wb_valid;
    logic              wb_load;
    logic              wb_clr;
    logic              drain;    // current WAIT/DONE belongs to a buffer drain
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    mem_bus_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .load      (wb_load),
        .clr       (wb_clr),
        .load_addr (cpu_addr),
        .load_data (cpu_wdata),
        .valid     (wb_valid),
        .addr      (wb_addr),
        .data      (wb_data)
    );

    // A store is absorbed in IDLE when the buffer is free, or in the DONE of a
    // drain (the slot frees on that same WAIT->DONE edge).
    assign wb_load = ~rst & cpu_wrt &
                     (((state == IDLE) & ~wb_valid) | ((state == DONE) & drain));
    assign wb_clr  = (state == WAIT) & drain & (mem.mem_ack | tmo_hit);

    always_comb begin
        cpu_stall = 1'b0;
        case (state)
            IDLE:    cpu_stall = wb_valid ? req : (cpu_read & ~cpu_wrt);
            WAIT:    cpu_stall = drain ? req : 1'b1;
            // A load held behind a drain issues from the following IDLE.
            DONE:    cpu_stall = drain & cpu_read & ~cpu_wrt;
            default: cpu_stall = 1'b0;
        endcase
        if (rst) cpu_stall = 1'b0;
    end
`else
    always_comb begin
        cpu_stall = 1'b0;
        case (state)
            IDLE:    cpu_stall = req;
            WAIT:    cpu_stall = 1'b1;
            default: cpu_stall = 1'b0;
        endcase
        if (rst) cpu_stall = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            cpu_rdata <= '0;
            bus_err   <= 1'b0;
`ifdef MEM_BUS_WRITE_BUF_EN
            drain     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef MEM_BUS_WRITE_BUF_EN
                    // Pending buffered store goes out before anything else.
                    if (wb_valid) begin
                        addr_q  <= wb_addr;
                        wdata_q <= wb_data;
                        we_q    <= 1'b1;
                        req_q   <= 1'b1;
                        tmo_cnt <= '0;
                        drain   <= 1'b1;
                        state   <= WAIT;
                    end else
`endif
                    if (req) begin
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        we_q    <= cpu_wrt;   // read+write together is a write
                        req_q   <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= WAIT;
`ifdef MEM_BUS_WRITE_BUF_EN
                        drain   <= cpu_wrt;
`endif
                    end
                end
                WAIT: begin
                    if (mem.mem_ack) begin
                        req_q <= 1'b0;
                        if (!we_q) cpu_rdata <= mem.mem_rdata;
                        state <= DONE;
                    end else if (tmo_hit) begin
                        req_q   <= 1'b0;
                        if (!we_q) cpu_rdata <= MEM_BUS_ERR_DATA[DATA_W-1:0];
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Data-memory bus controller between the single-cycle CPU core's data port (`addr_bus`, `data_bus_out`, `mem_read`, `mem_wrt`, `data_bus_in`) and a variable-latency memory with a req/ack handshake. It registers each CPU load/store and drives it onto the memory bus. It stalls the core until the access completes, returns load data, and aborts accesses that never receive an ack.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 15, maximum WAIT cycles without `mem_ack` before abort; legal range 1..255.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `cpu_addr`  in  ADDR_W  CPU address (core `addr_bus`).
- `cpu_wdata`  in  DATA_W  store data (core `data_bus_out`).
- `cpu_read`  in  1  load request (core `mem_read`).
- `cpu_wrt`  in  1  store request (core `mem_wrt`).
- `cpu_rdata`  out  DATA_W  load data (core `data_bus_in`).
- `cpu_stall`  out  1  freezes the core's PC and register write while high.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_ack`  in  1  memory completion; read data is valid in the same cycle.
- `mem_rdata`  in  DATA_W  memory read data.
- `bus_err`  out  1  sticky timeout flag.

## Operation
- FSM states are IDLE, WAIT and DONE. All registers reset to IDLE/zero.
- Reset values: `cpu_rdata` = 0, `cpu_stall` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_req` = 0, `mem_we` = 0, `bus_err` = 0.
- Request means `cpu_read | cpu_wrt`. If both are asserted, the access is treated as a write.
- IDLE with a request:
  - `cpu_stall` = 1, combinational.
  - The controller latches `mem_addr`/`mem_wdata`/`mem_we` and sets `mem_req` = 1.
  - The next state is WAIT.
- IDLE without a request: `cpu_stall` = 0 and the FSM stays in IDLE.
- WAIT:
  - `cpu_stall` = 1, and `mem_req`, `mem_addr`, `mem_we`, `mem_wdata` are held stable.
  - On `mem_ack`, the controller drops `mem_req`, captures `mem_rdata` into `cpu_rdata` for reads only, and moves to DONE.
- DONE: `cpu_stall` = 0 for exactly one cycle, then the FSM returns to IDLE. DONE never re-issues an access, so the request the core still holds is not replayed.
- Timeout: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle without ack. When it reaches `TIMEOUT`:
  - `mem_req` drops.
  - `cpu_rdata` becomes all-ones for reads.
  - `bus_err` sets and stays set until reset.
  - The next state is DONE.
- An ack outside WAIT is ignored.
- `cpu_rdata` holds its value until the next read completes.
- An asserted `rst` at any point, including mid-WAIT, returns the controller to IDLE. `mem_req` drops asynchronously and the pending access is discarded.

## Timing
- A request is seen in IDLE at cycle T. `mem_req` is high from T+1.
- The earliest ack is at T+1, giving DONE at T+2, so the core stalls for at least 2 cycles (T, T+1).
- In general, an ack k cycles after T+1 gives a stall of 2+k cycles.
- Timeout abort: `mem_req` is high for exactly `TIMEOUT` cycles, and `bus_err` rises at DONE entry.
- Back-to-back accesses use one IDLE cycle between DONE and the next request's WAIT.

## Configuration
- `MEM_BUS_WRITE_BUF_EN` defined: a one-entry posted-write buffer is compiled in. It adds a valid flag plus an address/data register.
  - IDLE store with the buffer empty: the store is captured with `cpu_stall` = 0, and the drain to memory starts next cycle through WAIT/DONE with no stall.
  - Store while the buffer is occupied: the core stalls until the drain's DONE, then the store is captured.
  - Load while the buffer is occupied: the core stalls until the drain completes, then the load issues normally. This preserves ordering.
  - A drain that times out sets `bus_err`.
- `MEM_BUS_WRITE_BUF_EN` undefined: every store takes the full stalled handshake, and the buffer logic is absent.

## Structure
- Shared package (`mem_bus_pkg`): FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), the `MEM_BUS_ERR_DATA` all-ones constant, and the default `TIMEOUT`.
- One natural sub-module: `mem_bus_wbuf`, the posted-write buffer. It is instantiated only under `MEM_BUS_WRITE_BUF_EN`.

## Test plan
- Read 0x0000_0010, ack after 3 WAIT cycles with `mem_rdata` = 0x1234_5678 -> `cpu_stall` high for 5 cycles, `cpu_rdata` = 0x1234_5678 in DONE, `mem_we` = 0.
- Write 0xCAFE_0001 to 0x20, ack at the first WAIT cycle -> `mem_we` = 1 and `mem_wdata` = 0xCAFE_0001 stable while `mem_req` is high, stall for 2 cycles, `cpu_rdata` unchanged.
- Read held through DONE, then a new read to 0x24 -> exactly two memory transactions, one IDLE cycle between them.
- No ack, `TIMEOUT` = 15 -> `mem_req` high for 15 cycles, then `cpu_rdata` = 0xFFFF_FFFF and `bus_err` = 1, which stays set through later good accesses.
- `rst` pulsed mid-WAIT -> `mem_req` = 0 immediately, the FSM is in IDLE, all outputs are at reset values, and a following read completes normally.
- With `MEM_BUS_WRITE_BUF_EN`: store then immediate load to the same address -> the store takes 0 stall, the load stalls until the drain ack, and the memory sees the write before the read.
